sobel_frame_sequencer: RTL
==========================

Name: sobel_frame_sequencer

Overview:
Frame-level controller between the SPI pixel stream and the gray/sobel datapath (top_gray_sobel).
- Accepts a configured frame of input pixels over a valid/ready handshake.
- Issues one-cycle pixel strobes and mode selects to the datapath.
- Buffers datapath results for SPI readback, counts input and output pixels, and signals frame completion, overflow or timeout.

Parameters:
- MAX_PIXEL_BITS, 8, pixel width; matches shared parameter.
- FRAME_PX, 64, pixels per frame (input and output counts).
- TIMEOUT_CYC, 1024, max idle cycles in DRAIN with no datapath output.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cfg_start_i  in  1  one-cycle pulse; begins a frame (IDLE only)
- cfg_select_i  in  2  mode, latched at start
- abort_i  in  1  one-cycle pulse; cancels frame
- in_px_i  in  MAX_PIXEL_BITS  input pixel from SPI
- in_valid_i  in  1  input pixel valid
- in_ready_o  out  1  sequencer accepts input pixel
- dp_px_o  out  MAX_PIXEL_BITS  pixel to datapath
- dp_px_rdy_o  out  1  one-cycle strobe to datapath
- dp_select_o  out  2  datapath select
- dp_start_sobel_o  out  1  datapath sobel enable
- dp_px_i  in  MAX_PIXEL_BITS  datapath result
- dp_px_rdy_i  in  1  datapath result strobe
- out_px_o  out  MAX_PIXEL_BITS  buffered result to SPI
- out_valid_o  out  1  result valid
- out_ready_i  in  1  SPI consumed result
- busy_o  out  1  state != IDLE
- frame_done_o  out  1  one-cycle completion pulse
- err_overflow_o  out  1  sticky; cleared at next cfg_start_i
- err_timeout_o  out  1  sticky; cleared at next cfg_start_i

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: every output 0, state IDLE, counters 0, output buffer empty.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - cfg_start_i → latch cfg_select_i into dp_select_o.
  - Set dp_start_sobel_o = cfg_select_i[1].
  - Clear in_cnt, out_cnt, timeout counter and both error flags.
  - Go to LOAD next cycle.
- LOAD:
  - in_ready_o = !out_full.
  - Accept when in_valid_i && in_ready_o: register in_px_i into dp_px_o and pulse dp_px_rdy_o on the next cycle (latency 1); in_cnt++.
  - When the accept makes in_cnt == FRAME_PX → DRAIN. in_ready_o is 0 from that cycle on.
- Output buffer (single entry, all states except IDLE):
  - dp_px_rdy_i with buffer empty → capture dp_px_i; out_valid_o = 1 the next cycle; out_cnt++.
  - out_valid_o && out_ready_i → buffer empty.
  - Consume and capture in the same cycle → capture wins; buffer stays full with the new pixel.
  - dp_px_rdy_i with buffer full and no consume → new pixel dropped; err_overflow_o set; out_cnt still increments.
- DRAIN:
  - Timeout counter increments each cycle without dp_px_rdy_i and resets on each strobe.
  - out_cnt == FRAME_PX && buffer empty → DONE.
  - Counter reaches TIMEOUT_CYC → set err_timeout_o, flush buffer, go to IDLE. No frame_done_o in this case.
- DONE: frame_done_o = 1 for exactly one cycle, then IDLE. dp_start_sobel_o clears on entry to IDLE.
- Counters are $clog2(FRAME_PX+1) bits wide. in_cnt never exceeds FRAME_PX: extra in_valid_i is ignored (ready = 0).
- dp_px_rdy_i in IDLE is ignored; no count, no capture.
- abort_i in any non-IDLE state: next cycle go to IDLE, flush buffer, clear counters, drop any pending strobe. No frame_done_o.
- abort_i has priority over all other transitions. cfg_start_i outside IDLE is ignored.
- reset_i mid-frame behaves like abort and additionally clears both error flags.

Decomposition:
- Shared package (with MAX_PIXEL_BITS): seq_state_t enum {IDLE, LOAD, DRAIN, DONE}.
- Also in the package: select encoding constants SEL_PASS=2'b00, SEL_GRAY=2'b01, SEL_SOBEL=2'b10, SEL_GRAY_SOBEL=2'b11.
- One sub-module, seq_out_buffer: single-entry skid register with capture, consume and overflow detect.
- FSM and counters stay in the top module.

Test Plan:
- Gray frame, FRAME_PX=4: start with select=01, feed 4 pixels 10,20,30,40 back-to-back; datapath model echoes each after 2 cycles; out_ready_i held 1.
  → dp_px_rdy_o pulses 4 times, each one cycle after its accept; out_px_o gives 10,20,30,40; frame_done_o pulses once; in_ready_o = 0 after the 4th accept.
- Backpressure: out_ready_i = 0 with buffer full.
  → in_ready_o = 0 until out_ready_i = 1; then the accept resumes on the following cycle; no error.
- Overflow: out_ready_i = 0, datapath model strobes twice.
  → first pixel retained; err_overflow_o = 1 and stays 1; frame still completes when out_cnt reaches 4.
- Timeout: TIMEOUT_CYC=16, datapath returns only 3 of 4 results.
  → after 16 idle cycles in DRAIN, err_timeout_o = 1, state IDLE, no frame_done_o.
- Abort: abort_i after the 2nd accept.
  → next cycle busy_o = 0, out_valid_o = 0, counters 0; a new cfg_start_i runs a full frame normally.
- Sobel select: start with select=10.
  → dp_start_sobel_o = 1 throughout the frame and 0 after returning to IDLE; a cfg_start_i issued mid-frame changes neither dp_select_o nor dp_start_sobel_o.

Source files
------------

// File: rtl/sobel_frame_sequencer_pkg.sv
// rtl/sobel_frame_sequencer_pkg.sv - shared types and constants for the sobel frame sequencer
package sobel_frame_sequencer_pkg;

    localparam int MAX_PIXEL_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] SEL_PASS       = 2'b00;
    localparam logic [1:0] SEL_GRAY       = 2'b01;
    localparam logic [1:0] SEL_SOBEL      = 2'b10;
    localparam logic [1:0] SEL_GRAY_SOBEL = 2'b11;

endpackage

// File: rtl/sobel_frame_sequencer_out_buffer.sv
// rtl/sobel_frame_sequencer_out_buffer.sv - single-entry result buffer with capture, consume and overflow detect
module seq_out_buffer
    import sobel_frame_sequencer_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      enable_i,
    input  logic                      cap_i,
    input  logic [MAX_PIXEL_BITS-1:0] px_i,
    input  logic                      consume_i,
    output logic [MAX_PIXEL_BITS-1:0] px_o,
    output logic                      valid_o,
    output logic                      overflow_o
);

    logic                      r_valid;
    logic [MAX_PIXEL_BITS-1:0] r_px;
    logic                      w_consume;
    logic                      w_capture;

    assign w_consume  = r_valid && consume_i;
    // a capture in the same cycle as a consume refills the slot rather than dropping
    assign w_capture  = enable_i && cap_i && (!r_valid || w_consume);
    assign overflow_o = enable_i && cap_i && r_valid && !w_consume && !flush_i;
    assign px_o       = r_px;
    assign valid_o    = r_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_valid <= 1'b0;
            r_px    <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_px    <= px_i;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// rtl/sobel_frame_sequencer.sv - frame controller between the SPI pixel stream and the gray/sobel datapath
module sobel_frame_sequencer
    import sobel_frame_sequencer_pkg::*;
#(
    parameter int FRAME_PX    = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      cfg_start_i,
    input  logic [1:0]                cfg_select_i,
    input  logic                      abort_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_px_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [MAX_PIXEL_BITS-1:0] dp_px_o,
    output logic                      dp_px_rdy_o,
    output logic [1:0]                dp_select_o,
    output logic                      dp_start_sobel_o,
    input  logic [MAX_PIXEL_BITS-1:0] dp_px_i,
    input  logic                      dp_px_rdy_i,
    output logic [MAX_PIXEL_BITS-1:0] out_px_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      err_overflow_o,
    output logic                      err_timeout_o
);

    localparam int CW = $clog2(FRAME_PX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    seq_state_t                r_state;
    seq_state_t                w_next;
    logic [CW-1:0]             r_in_cnt;
    logic [CW-1:0]             r_out_cnt;
    logic [TW-1:0]             r_to_cnt;
    logic [1:0]                r_select;
    logic                      r_sobel;
    logic [MAX_PIXEL_BITS-1:0] r_dp_px;
    logic                      r_dp_rdy;
    logic                      r_err_ovf;
    logic                      r_err_to;

    logic w_active, w_abort, w_start, w_accept, w_last_in, w_strobe;
    logic w_drained, w_to_fire, w_flush, w_buf_valid, w_ovf;

    assign w_active   = (r_state != IDLE);
    assign w_abort    = abort_i && w_active;
    assign w_start    = cfg_start_i && (r_state == IDLE);
    assign in_ready_o = (r_state == LOAD) && !w_buf_valid;
    assign w_accept   = in_valid_i && in_ready_o && !abort_i;
    assign w_last_in  = w_accept && (r_in_cnt == CW'(FRAME_PX - 1));
    assign w_strobe   = dp_px_rdy_i && w_active;
    assign w_drained  = (r_out_cnt == CW'(FRAME_PX)) && !w_buf_valid;
    // completion is checked before the idle limit so a late final result still finishes the frame
    assign w_to_fire  = (r_state == DRAIN) && !w_drained && !dp_px_rdy_i
                        && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_flush    = w_abort || w_to_fire;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cfg_start_i) w_next = LOAD;
            LOAD:    if (w_last_in) w_next = DRAIN;
            DRAIN:   if (w_drained) w_next = DONE;
                     else if (w_to_fire) w_next = IDLE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_dp_px   <= '0;
            r_dp_rdy  <= 1'b0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_to_cnt  <= '0;
        end else if (w_abort) begin
            r_dp_rdy  <= 1'b0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_dp_rdy <= w_accept;
            if (w_accept) begin
                r_dp_px  <= in_px_i;
                r_in_cnt <= r_in_cnt + CW'(1);
            end
            if (w_start) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_to_cnt  <= '0;
            end else begin
                if (w_strobe && (r_out_cnt != CW'(FRAME_PX))) r_out_cnt <= r_out_cnt + CW'(1);
                if (r_state == DRAIN) r_to_cnt <= dp_px_rdy_i ? '0 : r_to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_select  <= SEL_PASS;
            r_sobel   <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_to  <= 1'b0;
        end else if (w_start) begin
            r_select  <= cfg_select_i;
            r_sobel   <= cfg_select_i[1];
            r_err_ovf <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            if (w_active && (w_next == IDLE)) r_sobel <= 1'b0;
            if (w_ovf && !w_abort) r_err_ovf <= 1'b1;
            if (w_to_fire && !w_abort) r_err_to <= 1'b1;
        end
    end

    seq_out_buffer u_out_buffer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (w_flush),
        .enable_i   (w_active),
        .cap_i      (dp_px_rdy_i),
        .px_i       (dp_px_i),
        .consume_i  (out_ready_i),
        .px_o       (out_px_o),
        .valid_o    (w_buf_valid),
        .overflow_o (w_ovf)
    );

    assign out_valid_o      = w_buf_valid;
    assign dp_px_o          = r_dp_px;
    assign dp_px_rdy_o      = r_dp_rdy;
    assign dp_select_o      = r_select;
    assign dp_start_sobel_o = r_sobel;
    assign busy_o           = w_active;
    assign frame_done_o     = (r_state == DONE);
    assign err_overflow_o   = r_err_ovf;
    assign err_timeout_o    = r_err_to;

endmodule
